// File: rtl/object_draw_seq.sv
// Multi-object draw sequencer: reads X/Y per object (or takes them from
// rand_in) and issues DRAW through the shared datapath handshake.
module object_draw_seq #(
  parameter int COUNT        = 8,
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int OPCODE_WIDTH = 4,
  parameter int INSTR_WIDTH  = 32,
  parameter int RESULT_WIDTH = 16,
  parameter int RAND_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_X_BASE = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] ADDR_Y_BASE = 16'h0200,
  parameter int ADDR_STRIDE  = 1,
  parameter logic [OPCODE_WIDTH-1:0] OPCODE_MEMREAD = 4'd1,
  parameter logic [OPCODE_WIDTH-1:0] OPCODE_DRAW    = 4'd2,
  parameter logic [COLOUR_WIDTH-1:0] COLOUR_DRAW    = 3'b101,
  parameter logic [COLOUR_WIDTH-1:0] COLOUR_ERASE   = 3'b000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    finished,
  input  logic                    mode_erase,
  input  logic                    use_rand,
  input  logic [ID_WIDTH-1:0]     n_objects,
  input  logic [RAND_WIDTH-1:0]   rand_in,
  input  logic                    finished_dp,
  input  logic [RESULT_WIDTH-1:0] result_dp,
  output logic                    start_dp,
  output logic [INSTR_WIDTH-1:0]  instruction_dp,
  output logic [ID_WIDTH-1:0]     drawn_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_LX_START, S_LX_DELAY, S_LX_WAIT,
    S_LY_START, S_LY_DELAY, S_LY_WAIT,
    S_D_START, S_D_DELAY, S_D_WAIT, S_NEXT
  } state_t;

  localparam logic [ID_WIDTH-1:0] COUNT_W = ID_WIDTH'(COUNT);
  localparam int DX = OPCODE_WIDTH;
  localparam int DY = DX + X_WIDTH;
  localparam int DC = DY + Y_WIDTH;
  localparam int DP = DC + COLOUR_WIDTH;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     idx_q, idx_d;
  logic [ID_WIDTH-1:0]     cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]     drawn_q, drawn_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic                    erase_q, erase_d;
  logic                    urand_q, urand_d;
  logic                    fin_q, fin_d;
  logic                    sdp_q, sdp_d;
  logic [INSTR_WIDTH-1:0]  ins_q, ins_d;

  logic [ID_WIDTH-1:0]     n_clamp;
  logic [ADDR_WIDTH-1:0]   off;
  logic [INSTR_WIDTH-1:0]  rd_x, rd_y, draw;
  logic [X_WIDTH-1:0]      x_sel;
  logic [Y_WIDTH-1:0]      y_sel;
  logic                    unused_ok;

  // Only the low coordinate bits of the sources are meaningful.
  assign unused_ok = ^{result_dp, rand_in};

  always_comb begin
    n_clamp = (n_objects > COUNT_W) ? COUNT_W : n_objects;
    off     = ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(ADDR_STRIDE);

    rd_x = '0;
    rd_x[OPCODE_WIDTH-1:0] = OPCODE_MEMREAD;
    rd_x[DX +: ADDR_WIDTH] = ADDR_X_BASE + off;
    rd_y = '0;
    rd_y[OPCODE_WIDTH-1:0] = OPCODE_MEMREAD;
    rd_y[DX +: ADDR_WIDTH] = ADDR_Y_BASE + off;

    draw = '0;
    draw[OPCODE_WIDTH-1:0] = OPCODE_DRAW;
    draw[DX +: X_WIDTH]    = x_q;
    draw[DY +: Y_WIDTH]    = y_q;
    draw[DC +: COLOUR_WIDTH] = erase_q ? COLOUR_ERASE : COLOUR_DRAW;
    draw[DP] = 1'b1;

    x_sel = urand_q ? rand_in[X_WIDTH-1:0] : result_dp[X_WIDTH-1:0];
    y_sel = urand_q ? rand_in[Y_WIDTH-1:0] : result_dp[Y_WIDTH-1:0];

    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drawn_d = drawn_q;
    x_d     = x_q;
    y_d     = y_q;
    erase_d = erase_q;
    urand_d = urand_q;
    fin_d   = fin_q;
    sdp_d   = sdp_q;
    ins_d   = ins_q;

    unique case (state_q)
      S_IDLE: begin
        fin_d = 1'b1;
        if (start) begin
          erase_d = mode_erase;
          urand_d = use_rand;
          cnt_d   = n_clamp;
          idx_d   = '0;
          drawn_d = '0;
          fin_d   = 1'b0;
          state_d = (n_clamp == '0) ? S_NEXT : S_LX_START;
        end
      end
      S_LX_START: begin
        sdp_d   = 1'b1;
        ins_d   = rd_x;
        state_d = S_LX_DELAY;
      end
      S_LX_DELAY: state_d = S_LX_WAIT;
      S_LX_WAIT: begin
        sdp_d = 1'b0;
        if (finished_dp) begin
          x_d = x_sel;
          // An all-ones X in memory marks an empty slot.
          if (!urand_q && (x_sel == '1)) state_d = S_NEXT;
          else state_d = S_LY_START;
        end
      end
      S_LY_START: begin
        sdp_d   = 1'b1;
        ins_d   = rd_y;
        state_d = S_LY_DELAY;
      end
      S_LY_DELAY: state_d = S_LY_WAIT;
      S_LY_WAIT: begin
        sdp_d = 1'b0;
        if (finished_dp) begin
          y_d     = y_sel;
          state_d = S_D_START;
        end
      end
      S_D_START: begin
        sdp_d   = 1'b1;
        ins_d   = draw;
        state_d = S_D_DELAY;
      end
      S_D_DELAY: state_d = S_D_WAIT;
      S_D_WAIT: begin
        sdp_d = 1'b0;
        if (finished_dp) begin
          drawn_d = drawn_q + 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        idx_d = idx_q + 1'b1;
        if ((idx_d == cnt_q) || (cnt_q == '0)) state_d = S_IDLE;
        else state_d = S_LX_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drawn_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      erase_q <= 1'b0;
      urand_q <= 1'b0;
      fin_q   <= 1'b1;
      sdp_q   <= 1'b0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drawn_q <= drawn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      erase_q <= erase_d;
      urand_q <= urand_d;
      fin_q   <= fin_d;
      sdp_q   <= sdp_d;
      ins_q   <= ins_d;
    end
  end

  assign finished       = fin_q;
  assign start_dp       = sdp_q;
  assign instruction_dp = ins_q;
  assign drawn_count    = drawn_q;

endmodule

// File: tb/tb_object_draw_seq.sv
// Directed bench for object_draw_seq with a behavioural datapath mock.
module tb_object_draw_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        finished;
  logic        mode_erase = 1'b0;
  logic        use_rand = 1'b0;
  logic [3:0]  n_objects = '0;
  logic [7:0]  rand_in = '0;
  logic        finished_dp = 1'b0;
  logic [15:0] result_dp = '0;
  logic        start_dp;
  logic [31:0] instruction_dp;
  logic [3:0]  drawn_count;

  object_draw_seq dut (
    .clock(clock), .reset(reset), .start(start), .finished(finished),
    .mode_erase(mode_erase), .use_rand(use_rand), .n_objects(n_objects),
    .rand_in(rand_in), .finished_dp(finished_dp), .result_dp(result_dp),
    .start_dp(start_dp), .instruction_dp(instruction_dp),
    .drawn_count(drawn_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:1023];
  logic [31:0] ilog[$];
  int          plog[$];
  int          ibase, pbase;
  logic        mock_rst = 1'b1;
  logic [15:0] stall_addr = 16'hFFFF;
  int          stall_lat = 60;
  int          lat = 3;

  logic        busy = 1'b0, prev = 1'b0;
  int          cnt = 0, hi = 0;
  logic [31:0] cur = '0;

  // Datapath mock: accepts a request on start_dp, answers after a latency.
  always @(negedge clock) begin
    if (mock_rst) begin
      busy = 1'b0; prev = 1'b0; hi = 0; cnt = 0;
      finished_dp = 1'b0;
    end else begin
      if (start_dp) begin
        if (!prev) ilog.push_back(instruction_dp);
        hi++;
      end else if (prev) begin
        plog.push_back(hi);
        hi = 0;
      end
      prev = start_dp;
      if (start_dp && !busy) begin
        busy = 1'b1;
        finished_dp = 1'b0;
        cur = instruction_dp;
        cnt = (cur[3:0] == 4'd1 && cur[19:4] == stall_addr) ? stall_lat : lat;
      end else if (busy && !start_dp) begin
        if (cnt == 0) begin
          busy = 1'b0;
          finished_dp = 1'b1;
          result_dp = (cur[3:0] == 4'd1) ? mem[cur[13:4]] : 16'h0;
        end else cnt--;
      end
    end
  end

  function automatic logic [31:0] mr(input logic [15:0] a);
    return {12'h0, a, 4'd1};
  endfunction

  function automatic logic [31:0] dr(input logic [7:0] x,
                                     input logic [6:0] y,
                                     input logic [2:0] c);
    return {9'h0, 1'b1, c, y, x, 4'd2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int bad_pulses();
    int b = 0;
    for (int k = pbase; k < plog.size(); k++) if (plog[k] != 2) b++;
    return b;
  endfunction

  task automatic chk_log(input string nm, input logic [31:0] exp[$]);
    logic [31:0] a;
    chk({nm, "_len"}, ilog.size() - ibase, exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      a = (ibase + k < ilog.size()) ? ilog[ibase + k] : 32'hDEADBEEF;
      chk($sformatf("%s_%0d", nm, k), a, exp[k]);
    end
  endtask

  task automatic run_pass(input string nm, input logic [3:0] n,
                          input logic er, input logic ur,
                          input logic [7:0] rv, output int cyc);
    ibase = ilog.size();
    pbase = plog.size();
    @(negedge clock);
    n_objects = n; mode_erase = er; use_rand = ur; rand_in = rv;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    chk({nm, "_done"}, finished, 1'b1);
  endtask

  typedef struct {
    logic [3:0]  n;
    logic        er;
    logic        ur;
    logic [7:0]  rv;
    int          ops;
    logic [3:0]  drawn;
    logic        has_last;
    logic [31:0] last;
  } vec_t;

  vec_t vt[6];

  initial begin
    int cyc, sbad, ibad;
    logic [31:0] exp_q[$];
    logic [31:0] lastx;

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    for (int i = 0; i < 8; i++) begin
      mem[10'h100 + i] = 16'(10 + 20 * i);
      mem[10'h200 + i] = 16'(20 + 20 * i);
    end

    vt[0] = '{4'd2,  1'b0, 1'b0, 8'h00, 6,  4'd2, 1'b1, dr(30, 40, 5)};
    vt[1] = '{4'd1,  1'b1, 1'b1, 8'hC7, 3,  4'd1, 1'b1, dr(8'hC7, 7'h47, 0)};
    vt[2] = '{4'd12, 1'b0, 1'b0, 8'h00, 24, 4'd8, 1'b1, dr(150, 32, 5)};
    vt[3] = '{4'd0,  1'b0, 1'b0, 8'h00, 0,  4'd0, 1'b0, 32'h0};
    vt[4] = '{4'd8,  1'b0, 1'b1, 8'hFF, 24, 4'd8, 1'b1, dr(8'hFF, 7'h7F, 5)};
    vt[5] = '{4'd3,  1'b1, 1'b0, 8'h00, 9,  4'd3, 1'b1, dr(50, 60, 0)};

    repeat (3) @(negedge clock);
    chk("rst_finished", finished, 1'b1);
    chk("rst_start_dp", start_dp, 1'b0);
    chk("rst_instr", instruction_dp, 32'h0);
    chk("rst_drawn", drawn_count, 4'd0);
    reset = 1'b0;
    mock_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_pass($sformatf("v%0d", i), vt[i].n, vt[i].er, vt[i].ur,
               vt[i].rv, cyc);
      chk($sformatf("v%0d_drawn", i), drawn_count, vt[i].drawn);
      chk($sformatf("v%0d_ops", i), ilog.size() - ibase, vt[i].ops);
      chk($sformatf("v%0d_pulse2", i), bad_pulses(), 0);
      if (vt[i].has_last)
        chk($sformatf("v%0d_last", i), ilog[ilog.size() - 1], vt[i].last);
      if (vt[i].n == 4'd0)
        chk("zero_fast", cyc <= 3, 1'b1);
    end

    // Instruction order for a two-object memory pass
    run_pass("ord", 4'd2, 1'b0, 1'b0, 8'h00, cyc);
    exp_q = '{mr(16'h100), mr(16'h200), dr(10, 20, 5),
              mr(16'h101), mr(16'h201), dr(30, 40, 5)};
    chk_log("ord", exp_q);
    chk("ord_drawn", drawn_count, 4'd2);

    // Inactive slot 1 is skipped
    mem[10'h101] = 16'h00FF;
    run_pass("skip", 4'd3, 1'b0, 1'b0, 8'h00, cyc);
    exp_q = '{mr(16'h100), mr(16'h200), dr(10, 20, 5),
              mr(16'h101), mr(16'h102), mr(16'h202), dr(50, 60, 5)};
    chk_log("skip", exp_q);
    chk("skip_drawn", drawn_count, 4'd2);
    mem[10'h101] = 16'd30;

    // Clamped pass reads X up to address 0x0107
    run_pass("clamp", 4'd12, 1'b0, 1'b0, 8'h00, cyc);
    lastx = 32'h0;
    for (int k = ibase; k < ilog.size(); k++)
      if (ilog[k][3:0] == 4'd1 && ilog[k][19:12] == 8'h01) lastx = ilog[k];
    chk("clamp_lastx", lastx, mr(16'h107));

    // Long stall in LY_WAIT with a stray start pulse
    stall_addr = 16'h0200;
    ibase = ilog.size();
    pbase = plog.size();
    @(negedge clock);
    n_objects = 4'd2; mode_erase = 1'b0; use_rand = 1'b0; rand_in = 8'h00;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!((ilog.size() - ibase) >= 2 && !start_dp) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("stall_reach", cyc < 200, 1'b1);
    sbad = 0;
    ibad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (start_dp) sbad++;
      if (instruction_dp !== mr(16'h200)) ibad++;
      if (k == 20) begin
        mode_erase = 1'b1; use_rand = 1'b1; n_objects = 4'd1;
        rand_in = 8'hC7; start = 1'b1;
      end
      if (k == 21) start = 1'b0;
    end
    chk("stall_sdp_low", sbad, 0);
    chk("stall_hold", ibad, 0);
    cyc = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    chk("stall_done", finished, 1'b1);
    exp_q = '{mr(16'h100), mr(16'h200), dr(10, 20, 5),
              mr(16'h101), mr(16'h201), dr(30, 40, 5)};
    chk_log("stall", exp_q);
    chk("stall_drawn", drawn_count, 4'd2);
    stall_addr = 16'hFFFF;
    mode_erase = 1'b0; use_rand = 1'b0;

    // Reset during D_DELAY, then a fresh pass from index 0
    ibase = ilog.size();
    @(negedge clock);
    n_objects = 4'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!(start_dp && instruction_dp[3:0] == 4'd2) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("mid_reach", cyc < 200, 1'b1);
    reset = 1'b1;
    mock_rst = 1'b1;
    #1;
    chk("mid_start_dp", start_dp, 1'b0);
    chk("mid_finished", finished, 1'b1);
    chk("mid_instr", instruction_dp, 32'h0);
    chk("mid_drawn", drawn_count, 4'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    mock_rst = 1'b0;
    run_pass("after", 4'd1, 1'b0, 1'b0, 8'h00, cyc);
    exp_q = '{mr(16'h100), mr(16'h200), dr(10, 20, 5)};
    chk_log("after", exp_q);
    chk("after_drawn", drawn_count, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
